// File: rtl/msk_aes_mc_column_feeder.sv
// msk_aes_mc_column_feeder: column-serial masked ShiftRows + MixColumns round stage with valid/ready framing.
// Define MSKAES_COLFEED_KEY_ADD_EN to fuse a sharewise AddRoundKey (extra in_key port) into each column write-back.

module MSKaesMC #(
   parameter int d = 2
) (
   input  logic [8*d-1:0] a0,
   input  logic [8*d-1:0] a1,
   input  logic [8*d-1:0] a2,
   input  logic [8*d-1:0] a3,
   output logic [8*d-1:0] b0,
   output logic [8*d-1:0] b1,
   output logic [8*d-1:0] b2,
   output logic [8*d-1:0] b3
);
   function automatic logic [7:0] xt(input logic [7:0] x);
      return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
   endfunction

   // MixColumns is GF(2)-linear, so each share index is transformed on its own
   for (genvar i = 0; i < d; i++) begin : g_sh
      logic [7:0] x0, x1, x2, x3, y0, y1, y2, y3;
      for (genvar j = 0; j < 8; j++) begin : g_bit
         assign x0[j] = a0[d*j+i];
         assign x1[j] = a1[d*j+i];
         assign x2[j] = a2[d*j+i];
         assign x3[j] = a3[d*j+i];
         assign b0[d*j+i] = y0[j];
         assign b1[d*j+i] = y1[j];
         assign b2[d*j+i] = y2[j];
         assign b3[d*j+i] = y3[j];
      end
      assign y0 = xt(x0) ^ xt(x1) ^ x1 ^ x2 ^ x3;
      assign y1 = x0 ^ xt(x1) ^ xt(x2) ^ x2 ^ x3;
      assign y2 = x0 ^ x1 ^ xt(x2) ^ xt(x3) ^ x3;
      assign y3 = xt(x0) ^ x0 ^ x1 ^ x2 ^ xt(x3);
   end
endmodule

module msk_aes_mc_column_feeder #(
   parameter int d = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [128*d-1:0] in_state,
`ifdef MSKAES_COLFEED_KEY_ADD_EN
   input  logic [128*d-1:0] in_key,
`endif
   input  logic             in_bypass_mc,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [128*d-1:0] out_state
);
   localparam int W = 128*d;
   localparam int C = 32*d;
   localparam int B = 8*d;

   typedef enum logic [1:0] {IDLE, COL, OUT} fsm_t;

   fsm_t           fsm, fsm_nx;
   logic [1:0]     cnt;
   logic           byp, load;
   logic [W-1:0]   st, st_nx, sr;
   logic [C-1:0]   cols [4];
   logic [C-1:0]   col, mc, mx, wb;

   // ShiftRows is pure rewiring: byte (r,c) takes byte (r,(c+r)%4)
   for (genvar c = 0; c < 4; c++) begin : g_col
      for (genvar r = 0; r < 4; r++) begin : g_row
         assign sr[(4*c+r)*B +: B] = in_state[(4*((c+r)%4)+r)*B +: B];
      end
      assign cols[c] = st[c*C +: C];
      assign st_nx[c*C +: C] = load ? sr[c*C +: C]
                             : (fsm == COL && cnt == 2'(c)) ? wb : st[c*C +: C];
   end

   assign col = cols[cnt];

   MSKaesMC #(.d(d)) u_mc (
      .a0(col[0 +: B]),   .a1(col[B +: B]),   .a2(col[2*B +: B]), .a3(col[3*B +: B]),
      .b0(mc[0 +: B]),    .b1(mc[B +: B]),    .b2(mc[2*B +: B]),  .b3(mc[3*B +: B])
   );

   assign mx = byp ? col : mc;

`ifdef MSKAES_COLFEED_KEY_ADD_EN
   logic [W-1:0] key;
   logic [C-1:0] kcols [4];
   for (genvar c = 0; c < 4; c++) begin : g_key
      assign kcols[c] = key[c*C +: C];
   end
   assign wb = mx ^ kcols[cnt];
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) key <= '0;
      else if (load) key <= in_key;
   end
`else
   assign wb = mx;
`endif

   always_comb begin
      in_ready = (fsm == IDLE) || (fsm == OUT && out_ready);
      out_valid = (fsm == OUT);
      load = in_valid && in_ready;
      fsm_nx = load ? COL
             : (fsm == COL && cnt == 2'd3) ? OUT
             : (fsm == OUT && out_ready) ? IDLE : fsm;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fsm <= IDLE;
         cnt <= 2'd0;
         st  <= '0;
         byp <= 1'b0;
      end else begin
         fsm <= fsm_nx;
         st  <= st_nx;
         cnt <= load ? 2'd0 : (fsm == COL) ? cnt + 2'd1 : cnt;
         byp <= load ? in_bypass_mc : byp;
      end
   end

   assign out_state = st;
endmodule

// File: tb/tb_msk_aes_mc_column_feeder.sv
// tb_msk_aes_mc_column_feeder: directed checks of latency, bypass, backpressure, reset and share separation (d=2).
module tb_msk_aes_mc_column_feeder;
   localparam logic [127:0] NOM_IN  = {4{32'h455313db}};
   localparam logic [127:0] NOM_OUT = {4{32'hbca14d8e}};
   localparam logic [127:0] BYP_IN  = 128'h0f0e0d0c_0b0a0908_07060504_03020100;
   localparam logic [127:0] BYP_OUT = 128'h0b06010c_07020d08_030e0904_0f0a0500;
`ifdef MSKAES_COLFEED_KEY_ADD_EN
   localparam logic [127:0] EXP_NOM = NOM_OUT ^ {16{8'h01}};
   localparam logic [127:0] EXP_BYP = BYP_OUT ^ {16{8'h01}};
`else
   localparam logic [127:0] EXP_NOM = NOM_OUT;
   localparam logic [127:0] EXP_BYP = BYP_OUT;
`endif

   logic clk = 0, rst_n = 0, in_valid = 0, in_bypass_mc = 0, out_ready = 1;
   logic in_ready, out_valid;
   logic [255:0] in_state = '0, out_state, snap;
   int tests = 0, fails = 0;

`ifdef MSKAES_COLFEED_KEY_ADD_EN
   logic [255:0] in_key = '0;
   logic [127:0] kv = {16{8'h01}}, km = '0;
`endif

   msk_aes_mc_column_feeder #(.d(2)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_state(in_state),
`ifdef MSKAES_COLFEED_KEY_ADD_EN
      .in_key(in_key),
`endif
      .in_bypass_mc(in_bypass_mc), .out_valid(out_valid), .out_ready(out_ready), .out_state(out_state)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   function automatic logic [127:0] rnd();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   function automatic logic [255:0] msk(input logic [127:0] v, input logic [127:0] m);
      logic [255:0] s;
      for (int k = 0; k < 16; k++)
         for (int j = 0; j < 8; j++) begin
            s[16*k+2*j]   = v[8*k+j] ^ m[8*k+j];
            s[16*k+2*j+1] = m[8*k+j];
         end
      return s;
   endfunction

   function automatic logic [127:0] sh(input logic [255:0] s, input int i);
      logic [127:0] v;
      for (int k = 0; k < 16; k++)
         for (int j = 0; j < 8; j++) v[8*k+j] = s[16*k+2*j+i];
      return v;
   endfunction

   function automatic logic [127:0] um(input logic [255:0] s);
      return sh(s, 0) ^ sh(s, 1);
   endfunction

   task automatic chk(input string tag, input logic [255:0] o, input logic [255:0] e);
      tests++;
      assert (o === e) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, o, e);
      end
   endtask

   // drives one transfer and returns at the negedge of cycle T+1
   task automatic load(input logic [255:0] s, input logic b);
      int n = 0;
      while (!in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("load_ready", in_ready, 1'b1);
      in_state = s;
      in_bypass_mc = b;
`ifdef MSKAES_COLFEED_KEY_ADD_EN
      in_key = msk(kv, km);
`endif
      in_valid = 1;
      @(negedge clk);
      in_valid = 0;
   endtask

   // from T+1, checks busy/latency and returns at the negedge of cycle T+5
   task automatic wait_out(input string tag);
      chk({tag, "_busy_ready"}, in_ready, 1'b0);
      chk({tag, "_busy_valid"}, out_valid, 1'b0);
      repeat (3) @(negedge clk);
      chk({tag, "_valid_t4"}, out_valid, 1'b0);
      @(negedge clk);
      chk({tag, "_valid_t5"}, out_valid, 1'b1);
   endtask

   initial begin
`ifdef MSKAES_COLFEED_KEY_ADD_EN
      km = rnd();
`endif
      repeat (2) @(negedge clk);
      chk("rst_valid", out_valid, 1'b0);
      chk("rst_state", out_state, '0);
      chk("rst_ready", in_ready, 1'b1);
      rst_n = 1;
      @(negedge clk);

      load(msk(NOM_IN, rnd()), 0);
      wait_out("nom");
      chk("nom_data", um(out_state), EXP_NOM);

      @(negedge clk);
      load(msk(BYP_IN, rnd()), 1);
      wait_out("byp");
      chk("byp_data", um(out_state), EXP_BYP);

      @(negedge clk);
      out_ready = 0;
      load(msk(NOM_IN, rnd()), 0);
      wait_out("bp");
      snap = out_state;
      chk("bp_data", um(snap), EXP_NOM);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("bp_hold_valid", out_valid, 1'b1);
         chk("bp_hold_state", out_state, snap);
         chk("bp_hold_ready", in_ready, 1'b0);
      end
      out_ready = 1;
      in_valid = 1;
      #1;
      chk("b2b_ready", in_ready, 1'b1);
      load(msk(BYP_IN, rnd()), 1);
      wait_out("b2b");
      chk("b2b_data", um(out_state), EXP_BYP);

      @(negedge clk);
      load(msk(NOM_IN, rnd()), 0);
      repeat (2) @(negedge clk);
      rst_n = 0;
      #1;
      chk("midrst_valid", out_valid, 1'b0);
      chk("midrst_state", out_state, '0);
      @(negedge clk);
      rst_n = 1;
      @(negedge clk);
      chk("postrst_ready", in_ready, 1'b1);
      load(msk(NOM_IN, rnd()), 0);
      wait_out("postrst");
      chk("postrst_data", um(out_state), EXP_NOM);

      for (int r = 0; r < 100; r++) begin
         @(negedge clk);
         load(msk(NOM_IN, rnd()), 0);
         wait_out("indep");
         chk("indep_data", um(out_state), EXP_NOM);
      end

`ifdef MSKAES_COLFEED_KEY_ADD_EN
      kv = '0;
      km = '0;
`endif
      @(negedge clk);
      load(msk(NOM_IN, '0), 0);
      wait_out("sh0");
      chk("sh0_share0", sh(out_state, 0), NOM_OUT);
      chk("sh0_share1", sh(out_state, 1), '0);
      @(negedge clk);
      load(msk(NOM_IN, NOM_IN), 0);
      wait_out("sh1");
      chk("sh1_share0", sh(out_state, 0), '0);
      chk("sh1_share1", sh(out_state, 1), NOM_OUT);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/msk_aes_mc_column_feeder.md
Name: msk_aes_mc_column_feeder

Overview:
- Column-serial masked round datapath that wraps the team's sharewise MixColumns block (MSKaesMC).
- Accepts a full masked 128-bit AES state, applies ShiftRows on load, then streams one column per cycle through an internal MSKaesMC instance.
- Writes each result back, with optional fused sharewise AddRoundKey.
- Presents the full round output over a valid/ready handshake; sits between the S-box layer output and the next-round state register.

Parameters:
d, 2, number of shares (masking order d-1); must be >= 2.

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  input state valid
in_ready  output  1  block can accept a state
in_state  input  128*d  masked state; byte k at [8*d*k +: 8*d], row k%4, column k/4; within a byte, bit j share i at index d*j+i
in_bypass_mc  input  1  final round: skip MixColumns; sampled on input transfer
out_valid  output  1  output state valid
out_ready  input  1  consumer accepts output
out_state  output  128*d  masked round result, same layout as in_state

Behaviour:
- Reset: asynchronous on rst_n low. FSM->IDLE, cnt->0, state register->all zeros, bypass flag->0, out_valid->0, out_state->0. Transfers are ignored while rst_n is low.
- FSM states: IDLE, COL, OUT.
- in_ready = (fsm==IDLE) | (fsm==OUT & out_ready). This is combinational.
- Input transfer (in_valid & in_ready):
  - Register <= ShiftRows(in_state), applied per share by pure byte rewiring: out byte (r,c) = in byte (r,(c+r)%4).
  - Bypass flag <= in_bypass_mc.
  - cnt <= 0; fsm -> COL.
- COL, each cycle:
  - Column cnt (bytes 4*cnt..4*cnt+3) drives MSKaesMC a0..a3.
  - Result b0..b3, or the unmodified column when bypass is set, is written back to the same column.
  - cnt increments; at cnt==3, fsm -> OUT and cnt wraps to 0.
- OUT:
  - out_valid=1; out_state = register.
  - Held stable until out_ready.
  - out_ready & no new input -> IDLE.
  - out_ready & in_valid -> new load, fsm -> COL (back-to-back).
- Latency: transfer at edge ending cycle T; COL in cycles T+1..T+4; out_valid first high in T+5. Throughput is 1 state per 5 cycles.
- Masking rules:
  - Strictly sharewise; no gate combines different share indices.
  - All values written to the register go through registers; no share-mixing muxes.
  - The column-select mux is driven by public cnt only.
- in_valid while busy (COL) is not accepted; in_ready=0.
- Reset mid-operation discards the in-flight state: out_valid=0 and the register is zeroed immediately.

Optional Feature:
MSKAES_COLFEED_KEY_ADD_EN
- Defined:
  - Adds port in_key (input, 128*d, masked round key, same layout as in_state), registered on the input transfer.
  - Each COL write-back XORs the matching key column sharewise: share i with share i.
  - Bypass still applies the key (final round = ShiftRows + AddRoundKey).
- Undefined: no in_key port, no key register; output = MixColumns(ShiftRows(in)), or ShiftRows(in) when bypassed.

Test Plan:
- Nominal, d=2, macro undefined: all four columns = (db,13,53,45), share1 random, share0 = value^share1 -> unmasked out_state all columns (8e,4d,a1,bc); out_valid at T+5.
- Bypass: in bytes 0x00..0x0f with in_bypass_mc=1 -> unmasked output = ShiftRows(in) = 00 05 0a 0f 04 09 0e 03 08 0d 02 07 0c 01 06 0b.
- Key add with macro defined: nominal stimulus, key all 0x01 (random share split) -> columns (8f,4c,a0,bd); bypass with same key -> ShiftRows(in)^0x01 per byte.
- Backpressure and back-to-back: out_ready=0 for 10 cycles -> out_valid, out_state stable, in_ready=0. Then out_ready=1 with in_valid=1 -> second state accepted in the same cycle; second result 5 cycles later.
- Reset mid-operation: assert rst_n=0 at COL cnt=2 -> out_valid=0 and out_state=0 immediately. After release, in_ready=1 and a fresh nominal vector passes.
- Share independence: fix the unmasked state and vary share1 randomly over 100 runs -> recombined output constant; each output share depends only on the same-index input shares (check share0 output with share1 inputs forced to 0).
